// File: rtl/axi_port_monitor.sv
// Passive AXI4 protocol monitor for one NoC master port.
// Tracks outstanding bursts and beat counts and raises sticky violation flags.
// Optional handshake counters are built when AXI_MON_HS_CNT_EN is defined;
// otherwise hs_cnt is tied to zero.
module axi_port_monitor #(
  parameter int unsigned LEN_WIDTH       = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETn,
  input  logic                                   AWVALID,
  input  logic                                   AWREADY,
  input  logic [LEN_WIDTH-1:0]                   AWLEN,
  input  logic                                   WVALID,
  input  logic                                   WREADY,
  input  logic                                   WLAST,
  input  logic                                   BVALID,
  input  logic                                   BREADY,
  input  logic                                   ARVALID,
  input  logic                                   ARREADY,
  input  logic [LEN_WIDTH-1:0]                   ARLEN,
  input  logic                                   RVALID,
  input  logic                                   RREADY,
  input  logic                                   RLAST,
  output logic [7:0]                             err_flags,
  output logic                                   err_any,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   wr_outstanding,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   rd_outstanding,
  output logic [79:0]                            hs_cnt
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic [LEN_WIDTH-1:0] aw_mem [MAX_OUTSTANDING];
  logic [LEN_WIDTH-1:0] ar_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     aw_wr, aw_rd, ar_wr, ar_rd;
  logic [CNT_W-1:0]     aw_cnt;
  logic [LEN_WIDTH-1:0] w_beat, r_beat;
  logic prev_awvalid, prev_awready, prev_wvalid, prev_wready;
  logic prev_arvalid, prev_arready, prev_bvalid, prev_bready;
  logic prev_rvalid, prev_rready;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_full, ar_full, aw_ne, ar_ne;
  logic aw_push, aw_pop, ar_push, ar_pop;
  logic w_head_ok, w_chk, r_chk;
  logic [LEN_WIDTH-1:0] w_head_len;
  logic wr_zero, wr_inc, wr_dec;
  logic [7:0] flags_new;

  // Handshake decode, FIFO control and violation detection for this sample
  always_comb begin
    aw_hs = AWVALID & AWREADY;
    w_hs  = WVALID & WREADY;
    b_hs  = BVALID & BREADY;
    ar_hs = ARVALID & ARREADY;
    r_hs  = RVALID & RREADY;

    aw_full = (aw_cnt == CNT_MAX);
    ar_full = (rd_outstanding == CNT_MAX);
    aw_ne   = (aw_cnt != '0);
    ar_ne   = (rd_outstanding != '0);
    aw_push = aw_hs & ~aw_full;
    ar_push = ar_hs & ~ar_full;

    // A W beat may ride on an AW accepted in the same cycle
    w_head_ok  = aw_ne | aw_push;
    w_head_len = aw_ne ? aw_mem[aw_rd] : AWLEN;
    w_chk      = w_hs & w_head_ok;
    aw_pop     = w_chk & WLAST;
    r_chk      = r_hs & ar_ne;
    ar_pop     = r_chk & RLAST;

    wr_zero = (wr_outstanding == '0);
    wr_inc  = aw_push & (wr_outstanding != '1);
    wr_dec  = b_hs & ~wr_zero;

    flags_new    = '0;
    flags_new[0] = prev_awvalid & ~prev_awready & ~AWVALID;
    flags_new[1] = prev_wvalid & ~prev_wready & ~WVALID;
    flags_new[2] = prev_arvalid & ~prev_arready & ~ARVALID;
    flags_new[3] = prev_bready & ~prev_bvalid & ~BREADY;
    flags_new[4] = prev_rready & ~prev_rvalid & ~RREADY;
    flags_new[5] = w_chk & (WLAST != (w_beat == w_head_len));
    flags_new[6] = r_chk & (RLAST != (r_beat == ar_mem[ar_rd]));
    flags_new[7] = (w_hs & ~w_head_ok) | (b_hs & wr_zero) | (r_hs & ~ar_ne) |
                   (aw_hs & aw_full) | (ar_hs & ar_full);
  end

  // Burst length storage; contents are don't-care while the FIFO is empty
  always_ff @(posedge ACLK) begin
    if (aw_push) aw_mem[aw_wr] <= AWLEN;
    if (ar_push) ar_mem[ar_wr] <= ARLEN;
  end

  // Tracking state, previous-cycle samples and sticky flags
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_wr          <= '0;
      aw_rd          <= '0;
      ar_wr          <= '0;
      ar_rd          <= '0;
      aw_cnt         <= '0;
      w_beat         <= '0;
      r_beat         <= '0;
      prev_awvalid   <= 1'b0;
      prev_awready   <= 1'b0;
      prev_wvalid    <= 1'b0;
      prev_wready    <= 1'b0;
      prev_arvalid   <= 1'b0;
      prev_arready   <= 1'b0;
      prev_bvalid    <= 1'b0;
      prev_bready    <= 1'b0;
      prev_rvalid    <= 1'b0;
      prev_rready    <= 1'b0;
      err_flags      <= '0;
      err_any        <= 1'b0;
      wr_outstanding <= '0;
      rd_outstanding <= '0;
    end else begin
      prev_awvalid <= AWVALID;
      prev_awready <= AWREADY;
      prev_wvalid  <= WVALID;
      prev_wready  <= WREADY;
      prev_arvalid <= ARVALID;
      prev_arready <= ARREADY;
      prev_bvalid  <= BVALID;
      prev_bready  <= BREADY;
      prev_rvalid  <= RVALID;
      prev_rready  <= RREADY;

      if (aw_push) aw_wr <= (aw_wr == PTR_LAST) ? '0 : PTR_W'(aw_wr + 1'b1);
      if (aw_pop)  aw_rd <= (aw_rd == PTR_LAST) ? '0 : PTR_W'(aw_rd + 1'b1);
      if (ar_push) ar_wr <= (ar_wr == PTR_LAST) ? '0 : PTR_W'(ar_wr + 1'b1);
      if (ar_pop)  ar_rd <= (ar_rd == PTR_LAST) ? '0 : PTR_W'(ar_rd + 1'b1);

      if (aw_push && !aw_pop)      aw_cnt <= CNT_W'(aw_cnt + 1'b1);
      else if (!aw_push && aw_pop) aw_cnt <= CNT_W'(aw_cnt - 1'b1);

      if (ar_push && !ar_pop)      rd_outstanding <= CNT_W'(rd_outstanding + 1'b1);
      else if (!ar_push && ar_pop) rd_outstanding <= CNT_W'(rd_outstanding - 1'b1);

      if (wr_inc && !wr_dec)      wr_outstanding <= CNT_W'(wr_outstanding + 1'b1);
      else if (!wr_inc && wr_dec) wr_outstanding <= CNT_W'(wr_outstanding - 1'b1);

      if (w_chk) w_beat <= WLAST ? '0 : LEN_WIDTH'(w_beat + 1'b1);
      if (r_chk) r_beat <= RLAST ? '0 : LEN_WIDTH'(r_beat + 1'b1);

      err_flags <= err_flags | flags_new;
      err_any   <= |(err_flags | flags_new);
    end
  end

`ifdef AXI_MON_HS_CNT_EN
  logic [15:0] hs_aw, hs_w, hs_b, hs_ar, hs_r;

  // Saturating per-channel handshake counters
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      hs_aw <= '0;
      hs_w  <= '0;
      hs_b  <= '0;
      hs_ar <= '0;
      hs_r  <= '0;
    end else begin
      if (aw_hs && hs_aw != 16'hFFFF) hs_aw <= hs_aw + 16'd1;
      if (w_hs  && hs_w  != 16'hFFFF) hs_w  <= hs_w  + 16'd1;
      if (b_hs  && hs_b  != 16'hFFFF) hs_b  <= hs_b  + 16'd1;
      if (ar_hs && hs_ar != 16'hFFFF) hs_ar <= hs_ar + 16'd1;
      if (r_hs  && hs_r  != 16'hFFFF) hs_r  <= hs_r  + 16'd1;
    end
  end

  assign hs_cnt = {hs_aw, hs_w, hs_b, hs_ar, hs_r};
`else
  assign hs_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_port_monitor.sv
// Scoreboard bench for axi_port_monitor: expected outputs are queued with each
// driven cycle and compared once the DUT has taken the clock edge.
module tb_axi_port_monitor;

  localparam int unsigned CW = $clog2(8 + 1);

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [3:0] AWLEN, ARLEN;
  logic [7:0] err_flags;
  logic err_any;
  logic [CW-1:0] wr_outstanding, rd_outstanding;
  logic [79:0] hs_cnt;

  axi_port_monitor #(.LEN_WIDTH(4), .MAX_OUTSTANDING(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .err_flags(err_flags), .err_any(err_any),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
    .hs_cnt(hs_cnt)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    string          tag;
    logic [7:0]     flags;
    logic [CW-1:0]  wr;
    logic [CW-1:0]  rd;
    logic [79:0]    hs;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int unsigned e_aw, e_w, e_b, e_ar, e_r;

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] hs_exp();
`ifdef AXI_MON_HS_CNT_EN
    return {16'(e_aw), 16'(e_w), 16'(e_b), 16'(e_ar), 16'(e_r)};
`else
    return '0;
`endif
  endfunction

  task automatic drain();
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_val({e.tag, ".flags"}, 80'(err_flags), 80'(e.flags));
      check_val({e.tag, ".any"}, 80'(err_any), 80'(|e.flags));
      check_val({e.tag, ".wr"}, 80'(wr_outstanding), 80'(e.wr));
      check_val({e.tag, ".rd"}, 80'(rd_outstanding), 80'(e.rd));
      check_val({e.tag, ".hs"}, hs_cnt, e.hs);
    end
  endtask

  task automatic idle();
    AWVALID = 0; AWREADY = 0; AWLEN = 0;
    WVALID = 0; WREADY = 0; WLAST = 0;
    BVALID = 0; BREADY = 0;
    ARVALID = 0; ARREADY = 0; ARLEN = 0;
    RVALID = 0; RREADY = 0; RLAST = 0;
  endtask

  // Queue the expectation for the edge about to sample the current inputs
  task automatic step(input string tag, input logic [7:0] ef, input int unsigned ewr,
                      input int unsigned erd);
    exp_t e;
    if (AWVALID && AWREADY) e_aw++;
    if (WVALID && WREADY) e_w++;
    if (BVALID && BREADY) e_b++;
    if (ARVALID && ARREADY) e_ar++;
    if (RVALID && RREADY) e_r++;
    e.tag = tag; e.flags = ef; e.wr = CW'(ewr); e.rd = CW'(erd); e.hs = hs_exp();
    exp_q.push_back(e);
    @(posedge ACLK);
    #1;
    drain();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock
  task automatic do_reset(input string tag);
    exp_t e;
    ARESETn = 1'b0;
    idle();
    e_aw = 0; e_w = 0; e_b = 0; e_ar = 0; e_r = 0;
    #1;
    e.tag = tag; e.flags = '0; e.wr = '0; e.rd = '0; e.hs = '0;
    exp_q.push_back(e);
    drain();
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
  endtask

  initial begin
    idle();
    #2;
    do_reset("rst0");

    // Clean 4-beat write burst
    AWVALID = 1; AWREADY = 1; AWLEN = 3;
    step("s1_aw", 8'h00, 1, 0);
    AWVALID = 0; AWREADY = 0;
    for (int i = 0; i < 4; i++) begin
      WVALID = 1; WREADY = 1; WLAST = (i == 3);
      step($sformatf("s1_w%0d", i), 8'h00, 1, 0);
    end
    WVALID = 0; WREADY = 0; WLAST = 0;
    BVALID = 1; BREADY = 1;
    step("s1_b", 8'h00, 0, 0);
    idle();
    step("s1_idle", 8'h00, 0, 0);

    // AWVALID withdrawn before acceptance; sticky until reset
    AWVALID = 1; AWREADY = 0;
    step("s2_wait", 8'h00, 0, 0);
    AWVALID = 0;
    step("s2_drop", 8'h01, 0, 0);
    for (int i = 0; i < 2; i++) step("s2_hold", 8'h01, 0, 0);
    do_reset("s2_rst");

    // Early RLAST on a 2-beat read
    ARVALID = 1; ARREADY = 1; ARLEN = 1;
    step("s3_ar", 8'h00, 0, 1);
    idle();
    RVALID = 1; RREADY = 1; RLAST = 1;
    step("s3_r0", 8'h40, 0, 0);
    idle();
    step("s3_idle", 8'h40, 0, 0);
    do_reset("s3_rst");

    // Orphan B response
    BVALID = 1; BREADY = 1;
    step("s4_b", 8'h80, 0, 0);
    idle();
    step("s4_idle", 8'h80, 0, 0);
    do_reset("s4_rst");

    // AW FIFO overflow on the ninth address
    AWVALID = 1; AWREADY = 1; AWLEN = 0;
    for (int i = 1; i <= 9; i++)
      step($sformatf("s5_aw%0d", i), (i == 9) ? 8'h80 : 8'h00, (i == 9) ? 8 : i, 0);
    idle();
    step("s5_idle", 8'h80, 8, 0);
    do_reset("s5_rst");

    // Three single-beat reads, then reset in the middle of a write burst
    for (int i = 1; i <= 3; i++) begin
      ARVALID = 1; ARREADY = 1; ARLEN = 0;
      step($sformatf("s6_ar%0d", i), 8'h00, 0, i);
    end
    idle();
    for (int i = 1; i <= 3; i++) begin
      RVALID = 1; RREADY = 1; RLAST = 1;
      step($sformatf("s6_r%0d", i), 8'h00, 0, 3 - i);
    end
    idle();
    step("s6_idle", 8'h00, 0, 0);
    AWVALID = 1; AWREADY = 1; AWLEN = 3;
    step("s6_aw", 8'h00, 1, 0);
    AWVALID = 0; AWREADY = 0;
    WVALID = 1; WREADY = 1; WLAST = 0;
    step("s6_w0", 8'h00, 1, 0);
    do_reset("s6_rst");

    // W riding on a same-cycle AW
    AWVALID = 1; AWREADY = 1; AWLEN = 0;
    WVALID = 1; WREADY = 1; WLAST = 1;
    step("s7_aww", 8'h00, 1, 0);
    idle();
    BVALID = 1; BREADY = 1;
    step("s7_b", 8'h00, 0, 0);
    idle();
    // W with no address outstanding
    WVALID = 1; WREADY = 1; WLAST = 1;
    step("s7_orphw", 8'h80, 0, 0);
    idle();
    step("s7_idle", 8'h80, 0, 0);
    do_reset("s7_rst");

    // Missing WLAST on the final beat
    AWVALID = 1; AWREADY = 1; AWLEN = 1;
    step("s8_aw", 8'h00, 1, 0);
    AWVALID = 0; AWREADY = 0;
    WVALID = 1; WREADY = 1; WLAST = 0;
    step("s8_w0", 8'h00, 1, 0);
    step("s8_w1", 8'h20, 1, 0);
    idle();
    step("s8_idle", 8'h20, 1, 0);
    do_reset("s8_rst");

    // Ready withdrawn on B and R together
    BREADY = 1; RREADY = 1;
    step("s9_rdy", 8'h00, 0, 0);
    BREADY = 0; RREADY = 0;
    step("s9_drop", 8'h18, 0, 0);
    do_reset("s9_rst");

    // WVALID and ARVALID withdrawn together
    WVALID = 1; ARVALID = 1;
    step("s10_wait", 8'h00, 0, 0);
    WVALID = 0; ARVALID = 0;
    step("s10_drop", 8'h06, 0, 0);

    if (exp_q.size() != 0) check_val("leftover", 80'(exp_q.size()), 80'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_port_monitor.md
Name:
axi_port_monitor

Overview:
- Passive synthesizable AXI4 protocol monitor attached to one NoC master port (M0..M3) of the 4-master/7-slave interconnect.
- Observes the handshake signals, tracks outstanding bursts and beat counts, and raises sticky error flags for protocol violations.
- Drives no AXI signal.

Parameters:
- LEN_WIDTH, 4: burst length field width (AxLEN 0-15).
- MAX_OUTSTANDING, 8: depth of the AW and AR length FIFOs; the maximum outstanding bursts per direction.

Ports:
- ACLK  in  1  clock; all logic is posedge.
- ARESETn  in  1  asynchronous active-low reset.
- AWVALID  in  1  write address valid.
- AWREADY  in  1  write address ready.
- AWLEN  in  LEN_WIDTH  write burst length minus 1.
- WVALID  in  1  write data valid.
- WREADY  in  1  write data ready.
- WLAST  in  1  write last beat.
- BVALID  in  1  write response valid.
- BREADY  in  1  write response ready.
- ARVALID  in  1  read address valid.
- ARREADY  in  1  read address ready.
- ARLEN  in  LEN_WIDTH  read burst length minus 1.
- RVALID  in  1  read data valid.
- RREADY  in  1  read data ready.
- RLAST  in  1  read last beat.
- err_flags  out  8  sticky violation flags (bit map in Behaviour).
- err_any  out  1  OR of err_flags.
- wr_outstanding  out  $clog2(MAX_OUTSTANDING+1)  accepted AW without a B.
- rd_outstanding  out  $clog2(MAX_OUTSTANDING+1)  accepted AR without a final R.
- hs_cnt  out  80  {aw,w,b,ar,r} handshake counters, 16 bits each (optional feature).

Behaviour:
- Reset: all outputs 0, FIFOs empty, beat counters 0, previous-cycle samples 0. Reset is asynchronous; assertion mid-burst discards all tracking state.
- Handshake: xVALID & xREADY sampled at posedge ACLK.
- All outputs are registered. A flag sets on the edge after the violating sample.
- Flags are sticky until reset. Multiple flags may set in the same cycle.
- Stability checks compare against the previous-cycle sample:
  - bit0: AWVALID high and AWREADY low last cycle, AWVALID low now.
  - bit1: the same rule applied to WVALID/WREADY.
  - bit2: the same rule applied to ARVALID/ARREADY.
  - bit3: BREADY high and BVALID low last cycle, BREADY low now (team rule: ready is held once raised).
  - bit4: the same ready-hold rule applied to RREADY/RVALID.
- Write bursts:
  - An AW handshake pushes AWLEN.
  - A W handshake increments the write beat counter against the FIFO head.
  - bit5 sets if WLAST differs from (beat == head len).
  - The beat with WLAST pops the head and clears the counter.
- Read bursts (in order, no interleaving):
  - An AR handshake pushes ARLEN.
  - An R handshake is checked the same way against the AR FIFO head.
  - bit6 sets if RLAST differs from (beat == head len).
- bit7 sets on any of these; the offending push or pop is dropped:
  - W beat with AW FIFO empty (the port requires AW before or with W; same-cycle AW push is visible to that W).
  - B with wr_outstanding 0.
  - R with AR FIFO empty.
  - AW or AR handshake with the respective FIFO full.
- wr_outstanding increments on an AW handshake and decrements on a B handshake; simultaneous events leave it unchanged.
- rd_outstanding increments on an AR handshake and decrements on an R handshake with RLAST; simultaneous events leave it unchanged.

Optional Feature:
- AXI_MON_HS_CNT_EN defined: hs_cnt holds five 16-bit counters. Each increments per respective handshake, saturates at 0xFFFF, and resets to 0.
- Undefined: hs_cnt is tied to 0 and the counter logic is not built.

Test Plan:
- AW len=3 accepted, 4 W beats WLAST on 4th, B accepted -> err_flags=0x00, wr_outstanding 1 then 0.
- AWVALID high with AWREADY low, AWVALID dropped next cycle -> err_flags[0]=1, err_any=1, held until ARESETn low.
- AR len=1, R beat 0 carries RLAST -> err_flags[6]=1; rd_outstanding returns to 0.
- BVALID+BREADY with no AW accepted -> err_flags[7]=1, wr_outstanding stays 0.
- 9 AW handshakes with no B (MAX_OUTSTANDING=8) -> 9th sets err_flags[7], wr_outstanding=8.
- With AXI_MON_HS_CNT_EN: 3 AR, 3 R single beats -> hs_cnt ar=3, r=3, others 0. ARESETn mid-burst -> all outputs 0 immediately.
